// File: rtl/countdown_timer_pkg.sv
// Shared types and default sizes for the countdown timer.
package countdown_timer_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned PW_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE+1; tick is high on the last cycle of each group.
module tick_prescaler #(
  parameter int unsigned PW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic          CLR,
  input  logic [PW-1:0] PRESCALE,
  output logic          tick
);

  logic [PW-1:0] pcnt;
  logic          wrap;

  // >= so a PRESCALE lowered mid-count still wraps promptly
  assign wrap = (pcnt >= PRESCALE);
  assign tick = EN & wrap;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pcnt <= '0;
    end else if (CLR) begin
      pcnt <= '0;
    end else if (EN) begin
      pcnt <= wrap ? '0 : pcnt + PW'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot/periodic modes and a one-cycle tc pulse.
// Optional tick prescaler enabled by defining COUNTDOWN_TIMER_PRESCALER_EN.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned PW    = PW_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             START,
  input  logic             STOP,
  input  logic             AUTO_RELOAD,
`ifdef COUNTDOWN_TIMER_PRESCALER_EN
  input  logic [PW-1:0]    PRESCALE,
`endif
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             tc
);

  state_t           state, state_n;
  logic [WIDTH-1:0] reload, reload_n, cnt_n;
  logic             tc_n;
  logic             run;
  logic             tick;

  assign run = (state == RUN);

`ifdef COUNTDOWN_TIMER_PRESCALER_EN
  logic clr;
  assign clr = LOAD | START | STOP;

  tick_prescaler #(.PW(PW)) u_tick_prescaler (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN & run),
    .CLR      (clr),
    .PRESCALE (PRESCALE),
    .tick     (tick)
  );
`else
  logic unused_pw;
  assign unused_pw = ^PW;
  assign tick      = EN & run;
`endif

  // State and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      reload <= '0;
      busy   <= 1'b0;
      tc     <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      reload <= reload_n;
      busy   <= (state_n == RUN);
      tc     <= tc_n;
    end
  end

  // Control priority: LOAD > STOP > START > count
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    reload_n = reload;
    tc_n     = 1'b0;
    if (LOAD) begin
      cnt_n    = LOAD_VAL;
      reload_n = LOAD_VAL;
      state_n  = IDLE;
    end else if (STOP) begin
      if (state == RUN) state_n = IDLE;
    end else if (START && (state != RUN)) begin
      if (state == DONE) begin
        cnt_n = reload;
        if (reload != '0) state_n = RUN;
      end else if (cnt != '0) begin
        state_n = RUN;
      end
    end else if (run && tick) begin
      if (cnt > WIDTH'(1)) begin
        cnt_n = cnt - WIDTH'(1);
      end else if (AUTO_RELOAD) begin
        cnt_n = reload;
        tc_n  = 1'b1;
      end else begin
        cnt_n   = '0;
        tc_n    = 1'b1;
        state_n = DONE;
      end
    end
    if ((state != IDLE) && (state != RUN) && (state != DONE)) state_n = IDLE;
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed and randomized bench for countdown_timer against a behavioural model.
module tb_countdown_timer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0, LOAD = 1'b0, START = 1'b0, STOP = 1'b0, AUTO_RELOAD = 1'b0;
  logic [7:0] LOAD_VAL = '0;
  logic [7:0] cnt;
  logic       busy, tc;
`ifdef COUNTDOWN_TIMER_PRESCALER_EN
  logic [3:0] PRESCALE = '0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // model: mode 0 idle, 1 run, 2 done
  int m_cnt, m_rel, m_mode, m_pre, m_tc, m_ps;
  int tc_seen;

  always #5 CLK = ~CLK;

  countdown_timer dut (
    .CLK         (CLK),
    .RST         (RST),
    .EN          (EN),
    .LOAD        (LOAD),
    .LOAD_VAL    (LOAD_VAL),
    .START       (START),
    .STOP        (STOP),
    .AUTO_RELOAD (AUTO_RELOAD),
`ifdef COUNTDOWN_TIMER_PRESCALER_EN
    .PRESCALE    (PRESCALE),
`endif
    .cnt         (cnt),
    .busy        (busy),
    .tc          (tc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_rel = 0; m_mode = 0; m_pre = 0; m_tc = 0;
  endtask

  // One clock of the timer rules applied to the model
  task automatic model_update(input bit ld, input int lv, input bit st, input bit sp,
                              input bit ar, input bit en);
    bit tk;
    m_tc = 0;
    if (ld) begin
      m_cnt = lv; m_rel = lv; m_mode = 0; m_pre = 0;
    end else if (sp) begin
      if (m_mode == 1) m_mode = 0;
      m_pre = 0;
    end else if (st && m_mode != 1) begin
      m_pre = 0;
      if (m_mode == 2) begin
        m_cnt = m_rel;
        if (m_rel != 0) m_mode = 1;
      end else if (m_cnt != 0) begin
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      tk = en && (m_pre >= m_ps);
      if (en) m_pre = (m_pre >= m_ps) ? 0 : m_pre + 1;
      if (st) m_pre = 0;
      if (tk) begin
        if (m_cnt > 1) m_cnt = m_cnt - 1;
        else if (ar) begin m_cnt = m_rel; m_tc = 1; end
        else begin m_cnt = 0; m_tc = 1; m_mode = 2; end
      end
    end
  endtask

  task automatic step(input bit ld, input int lv, input bit st, input bit sp,
                      input bit ar, input bit en);
    LOAD = ld; LOAD_VAL = 8'(lv); START = st; STOP = sp; AUTO_RELOAD = ar; EN = en;
    @(posedge CLK);
    model_update(ld, lv & 255, st, sp, ar, en);
    #1;
    check("cnt", 32'(cnt), 32'(m_cnt));
    check("busy", 32'(busy), 32'(m_mode == 1));
    check("tc", 32'(tc), 32'(m_tc));
    LOAD = 1'b0; START = 1'b0; STOP = 1'b0;
  endtask

  initial begin
    m_ps = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_cnt", 32'(cnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tc", 32'(tc), 0);
    RST = 1'b0;

    // one-shot 3,2,1,0
    step(1, 3, 0, 0, 0, 1);
    check("os_load", 32'(cnt), 3);
    step(0, 0, 1, 0, 0, 1);
    check("os_start_busy", 32'(busy), 1);
    step(0, 0, 0, 0, 0, 1); check("os_2", 32'(cnt), 2);
    step(0, 0, 0, 0, 0, 1); check("os_1", 32'(cnt), 1); check("os_tc_early", 32'(tc), 0);
    step(0, 0, 0, 0, 0, 1); check("os_0", 32'(cnt), 0); check("os_tc", 32'(tc), 1);
    check("os_done_busy", 32'(busy), 0);
    step(0, 0, 0, 0, 0, 1); check("os_tc_once", 32'(tc), 0); check("os_hold0", 32'(cnt), 0);
    // START in DONE reloads
    step(0, 0, 1, 0, 0, 1); check("done_restart", 32'(cnt), 3); check("done_busy", 32'(busy), 1);

    // periodic reload 4
    step(1, 4, 0, 0, 1, 1);
    step(0, 0, 1, 0, 1, 1);
    tc_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0, 1, 1);
      if (tc) tc_seen++;
      check("ar_seq", 32'(cnt), 32'(3 - (i % 4) + ((i % 4) == 3 ? 4 : 0)));
      check("ar_tc", 32'(tc), 32'((i % 4) == 3));
    end
    check("ar_pulses", 32'(tc_seen), 3);

    // pause/resume and EN freeze
    step(1, 6, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1); check("pr_4", 32'(cnt), 4);
    step(0, 0, 0, 1, 0, 1); check("pr_stop", 32'(cnt), 4); check("pr_stop_busy", 32'(busy), 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 1); check("pr_hold", 32'(cnt), 4);
    end
    step(0, 0, 1, 0, 0, 1); check("pr_resume", 32'(cnt), 4); check("pr_busy", 32'(busy), 1);
    step(0, 0, 0, 0, 0, 1); check("pr_3", 32'(cnt), 3);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0); check("en_freeze", 32'(cnt), 3);
    end
    step(0, 0, 0, 0, 0, 1); check("pr_2", 32'(cnt), 2);

    // LOAD beats STOP and START; START with cnt 0 ignored
    step(1, 9, 1, 1, 0, 1); check("prio_cnt", 32'(cnt), 9); check("prio_busy", 32'(busy), 0);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1); check("zero_start", 32'(busy), 0); check("zero_cnt", 32'(cnt), 0);

    // async reset mid-RUN at cnt 5
    step(1, 7, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1); check("rr_5", 32'(cnt), 5);
    RST = 1'b1;
    #1;
    check("rr_cnt", 32'(cnt), 0);
    check("rr_busy", 32'(busy), 0);
    check("rr_tc", 32'(tc), 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0, 1); check("rr_quiet", 32'(tc), 0);
    end

`ifdef COUNTDOWN_TIMER_PRESCALER_EN
    PRESCALE = 4'd2; m_ps = 2;
    step(1, 2, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    for (int i = 1; i <= 6; i++) begin
      step(0, 0, 0, 0, 0, 1);
      check("ps_cnt", 32'(cnt), 32'(i < 3 ? 2 : (i < 6 ? 1 : 0)));
      check("ps_tc", 32'(tc), 32'(i == 6));
    end
`endif

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
`ifdef COUNTDOWN_TIMER_PRESCALER_EN
      if ($urandom_range(0, 99) == 0) begin
        PRESCALE = 4'($urandom_range(0, 3));
        m_ps = int'(PRESCALE);
      end
`endif
      step($urandom_range(0, 15) == 0,
           ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6)),
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the counter and load-value width in bits.
REQ-002 Parameter PW, default 4, SHALL set the prescaler width in bits; used only when the prescaler is compiled in.
REQ-003 CLK  input  1  SHALL be the clock; all state SHALL update on the rising edge.
REQ-004 RST  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 EN  input  1  SHALL be the count enable; when low, count and prescaler SHALL freeze.
REQ-006 LOAD  input  1  SHALL be a load strobe.
REQ-007 LOAD_VAL  input  WIDTH  SHALL be the start/reload value, sampled when LOAD=1.
REQ-008 START  input  1  SHALL start or resume counting.
REQ-009 STOP  input  1  SHALL pause counting.
REQ-010 AUTO_RELOAD  input  1  SHALL be the mode select: 1 = periodic, 0 = one-shot; sampled at each terminal count.
REQ-011 cnt  output  WIDTH  SHALL present the current count value.
REQ-012 busy  output  1  SHALL be high while in RUN.
REQ-013 tc  output  1  SHALL be the terminal-count pulse, one cycle wide.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 Control priority SHALL be LOAD > STOP > START > count, evaluated every cycle.
REQ-016 LOAD in any state: cnt<=LOAD_VAL, reload register<=LOAD_VAL, next state IDLE, tc=0.
REQ-017 START in IDLE: go to RUN if cnt!=0; if cnt==0, ignore and stay in IDLE.
REQ-018 START in DONE: cnt<=reload; go to RUN if reload!=0, else stay in DONE.
REQ-019 START while in RUN SHALL have no effect.
REQ-020 STOP in RUN: go to IDLE, hold cnt (pause); a later START resumes from the held value.
REQ-021 In RUN, on each tick: if cnt>1, cnt<=cnt-1.
REQ-022 In RUN, on a tick with cnt==1 and AUTO_RELOAD=1: cnt<=reload, tc=1 next cycle, stay in RUN; the period SHALL be exactly reload ticks.
REQ-023 In RUN, on a tick with cnt==1 and AUTO_RELOAD=0: cnt<=0, tc=1 next cycle, go to DONE.
REQ-024 tc SHALL be registered and high for exactly one cycle per terminal count, coincident with the first cycle showing the new cnt.
REQ-025 tick = EN when the prescaler is absent; cnt SHALL never wrap below 0.
REQ-026 busy SHALL be a registered decode of state==RUN.

Reset
REQ-027 On RST=1, immediately: cnt=0, reload=0, state=IDLE, busy=0, tc=0, prescaler count=0.
REQ-028 RST mid-RUN SHALL abort counting with no tc pulse; after RST is released, only LOAD or START SHALL cause activity.

Configuration
REQ-029 With macro COUNTDOWN_TIMER_PRESCALER_EN defined, input PRESCALE [PW-1:0] SHALL exist.
REQ-030 With the macro defined, tick SHALL be asserted once every PRESCALE+1 enabled RUN cycles; PRESCALE=0 SHALL give a tick every enabled cycle.
REQ-031 With the macro defined, the prescaler count SHALL clear on LOAD, START and STOP, and SHALL advance only when EN=1 and in RUN.
REQ-032 Without the macro: no PRESCALE port, no prescaler logic, and tick SHALL equal EN in RUN.

Structure
REQ-033 Shared package countdown_timer_pkg SHALL hold the state enum typedef (IDLE/RUN/DONE) and default constants WIDTH_DEF=8 and PW_DEF=4.
REQ-034 Sub-module tick_prescaler (parameter PW; ports CLK, RST, EN, CLR, PRESCALE, tick) SHALL exist and be instantiated only when COUNTDOWN_TIMER_PRESCALER_EN is defined.

Verification
REQ-035 RST=1 mid-RUN with cnt=5 -> cnt=0, busy=0, tc=0 in the same cycle; no tc afterwards.
REQ-036 LOAD_VAL=3, LOAD, START, EN=1, AUTO_RELOAD=0 -> cnt 3,2,1,0; tc high for exactly the cycle cnt first reads 0; state DONE, busy=0.
REQ-037 LOAD_VAL=4, AUTO_RELOAD=1, EN=1 for 12 cycles -> tc pulses every 4 cycles (3 pulses); cnt sequence 4,3,2,1,4,...; cnt never reads 0.
REQ-038 LOAD_VAL=6, START, STOP at cnt=4, hold 5 cycles, START -> cnt holds at 4, then resumes 3,2,...; EN=0 for 3 cycles during RUN freezes cnt.
REQ-039 Same cycle LOAD=1 (LOAD_VAL=9), STOP=1 and START=1 while in RUN -> cnt=9, state IDLE; START in IDLE with cnt=0 -> ignored, busy stays 0.
REQ-040 Macro defined, PRESCALE=2, LOAD_VAL=2, START, EN=1 -> cnt decrements every 3rd cycle; tc after 6 RUN cycles.
